// File: rtl/instr_exec_sequencer_pkg.sv
// Shared types for the instruction register and the execute sequencer.
// Holds the instruction/operand types plus the sequencer state encoding
// and the width of the optional stall counter (SEQ_STALL_CNT_EN).
package instr_register_pkg;

  // Opcode space is 4 bits wide; encodings 8..15 are undefined and execute as zero.
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  // Result is twice the operand width so a full product always fits.
  typedef logic signed [63:0] operand_r;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  localparam int SEQ_STALL_W = 16;

endpackage

// File: rtl/instr_exec_sequencer_if.sv
// Bus between the sequencer, the instruction register read port and the
// result consumer. The master modport is the sequencer side.
//
// Result handshake: a transfer happens on a rising clk edge where
// res_valid and res_ready are both 1. Once res_valid rises, res_valid,
// res_data, res_opcode and res_addr stay stable until that edge.
// res_valid never waits on res_ready; res_ready while res_valid is low
// has no effect.
interface instr_exec_sequencer_if
  import instr_register_pkg::*;
#(
  parameter int ADDR_W = 5
) ();

  logic [ADDR_W-1:0] read_pointer;
  instruction_t      instruction_word;
  logic              res_valid;
  logic              res_ready;
  operand_r          res_data;
  opcode_t           res_opcode;
  logic [ADDR_W-1:0] res_addr;

  modport master (
    output read_pointer,
    input  instruction_word,
    output res_valid,
    input  res_ready,
    output res_data,
    output res_opcode,
    output res_addr
  );

  modport slave (
    input  read_pointer,
    output instruction_word,
    input  res_valid,
    output res_ready,
    input  res_data,
    input  res_opcode,
    input  res_addr
  );

endinterface

// File: rtl/instr_exec_sequencer_alu.sv
// Combinational signed ALU used by the sequencer's execute step.
// Operands are sign-extended to the result width before any arithmetic,
// so ADD/SUB/MULT/DIV never overflow in the operand width.
module instr_alu
  import instr_register_pkg::*;
(
  input  opcode_t  opcode,
  input  operand_t operand_a,
  input  operand_t operand_b,
  output operand_r result,
  output logic     div_zero
);

  localparam int EXT_W = $bits(operand_r) - $bits(operand_t);

  operand_r a_x;
  operand_r b_x;

  // Evaluate the opcode; divide/modulo by zero yields 0 and raises div_zero.
  always_comb begin
    a_x      = {{EXT_W{operand_a[$bits(operand_t)-1]}}, operand_a};
    b_x      = {{EXT_W{operand_b[$bits(operand_t)-1]}}, operand_b};
    result   = '0;
    div_zero = 1'b0;
    case (opcode)
      ZERO:  result = '0;
      PASSA: result = a_x;
      PASSB: result = b_x;
      ADD:   result = a_x + b_x;
      SUB:   result = a_x - b_x;
      MULT:  result = a_x * b_x;
      DIV: begin
        if (operand_b == '0) div_zero = 1'b1;
        else                 result   = a_x / b_x;
      end
      MOD: begin
        if (operand_b == '0) div_zero = 1'b1;
        else                 result   = a_x % b_x;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_exec_sequencer.sv
// Instruction execute sequencer: on start, sweeps read_pointer over
// count entries from start_addr (wrapping modulo the register depth),
// executes each instruction and offers the result on a valid/ready port.
// Optional macro SEQ_STALL_CNT_EN adds a saturating 16-bit stall_cnt
// output counting RESP cycles with res_ready low.
module instr_exec_sequencer
  import instr_register_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      start_addr,
  input  logic [CNT_W-1:0]       count,
  instr_exec_sequencer_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   div_zero_err,
  output seq_state_t             state_dbg
`ifdef SEQ_STALL_CNT_EN
  ,
  output logic [SEQ_STALL_W-1:0] stall_cnt
`endif
);

  seq_state_t        state_q,      state_d;
  logic [ADDR_W-1:0] rp_q,         rp_d;
  logic [CNT_W-1:0]  rem_q,        rem_d;
  instruction_t      instr_q,      instr_d;
  logic              res_valid_q,  res_valid_d;
  operand_r          res_data_q,   res_data_d;
  opcode_t           res_opcode_q, res_opcode_d;
  logic [ADDR_W-1:0] res_addr_q,   res_addr_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;
  logic              dz_q,         dz_d;
`ifdef SEQ_STALL_CNT_EN
  logic [SEQ_STALL_W-1:0] stall_q, stall_d;
`endif

  operand_r alu_result;
  logic     alu_div_zero;

  // The ALU reads the latched instruction; its output is only consumed in EXEC.
  instr_alu u_alu (
    .opcode    (instr_q.opc),
    .operand_a (instr_q.op_a),
    .operand_b (instr_q.op_b),
    .result    (alu_result),
    .div_zero  (alu_div_zero)
  );

  // Next-state and next-output logic for the IDLE/FETCH/EXEC/RESP sweep.
  always_comb begin
    state_d      = state_q;
    rp_d         = rp_q;
    rem_d        = rem_q;
    instr_d      = instr_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_opcode_d = res_opcode_q;
    res_addr_d   = res_addr_q;
    dz_d         = dz_q;
    done_d       = 1'b0;
`ifdef SEQ_STALL_CNT_EN
    stall_d      = stall_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          // Any accepted start clears the sticky error, even an empty one.
          dz_d = 1'b0;
`ifdef SEQ_STALL_CNT_EN
          stall_d = '0;
`endif
          if (count != '0) begin
            state_d = FETCH;
            rp_d    = start_addr;
            rem_d   = count;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      FETCH: begin
        instr_d    = bus.instruction_word;
        res_addr_d = rp_q;
        state_d    = EXEC;
      end
      EXEC: begin
        res_data_d   = alu_result;
        res_opcode_d = instr_q.opc;
        res_valid_d  = 1'b1;
        if (alu_div_zero) dz_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          rem_d       = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
            rp_d    = rp_q + ADDR_W'(1);
          end
        end
`ifdef SEQ_STALL_CNT_EN
        else if (stall_q != '1) begin
          stall_d = stall_q + SEQ_STALL_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any sweep in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rp_q         <= '0;
      rem_q        <= '0;
      instr_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_opcode_q <= ZERO;
      res_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dz_q         <= 1'b0;
`ifdef SEQ_STALL_CNT_EN
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rp_q         <= rp_d;
      rem_q        <= rem_d;
      instr_q      <= instr_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_opcode_q <= res_opcode_d;
      res_addr_q   <= res_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dz_q         <= dz_d;
`ifdef SEQ_STALL_CNT_EN
      stall_q      <= stall_d;
`endif
    end
  end

  assign bus.read_pointer = rp_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_opcode   = res_opcode_q;
  assign bus.res_addr     = res_addr_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign div_zero_err     = dz_q;
  assign state_dbg        = state_q;
`ifdef SEQ_STALL_CNT_EN
  assign stall_cnt        = stall_q;
`endif

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Self-checking bench for instr_exec_sequencer. The instruction register
// is a plain array in the bench; expected results come from a longint
// arithmetic model of each opcode and are queued per sweep.
module tb_instr_exec_sequencer;
  import instr_register_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic              start;
  logic [4:0]        start_addr;
  logic [5:0]        count;
  logic              res_ready;
  logic              busy;
  logic              done;
  logic              div_zero_err;
  seq_state_t        state_dbg;
`ifdef SEQ_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  instruction_t mem [32];

  instr_exec_sequencer_if bus_if ();

  assign bus_if.res_ready = res_ready;
  always_comb bus_if.instruction_word = mem[bus_if.read_pointer];

  instr_exec_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .start_addr   (start_addr),
    .count        (count),
    .bus          (bus_if),
    .busy         (busy),
    .done         (done),
    .div_zero_err (div_zero_err),
    .state_dbg    (state_dbg)
`ifdef SEQ_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_checks   = 0;
  int n_failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint model_res(input instruction_t ins);
    longint a;
    longint b;
    a = longint'(ins.op_a);
    b = longint'(ins.op_b);
    case (ins.opc)
      ZERO:    return 0;
      PASSA:   return a;
      PASSB:   return b;
      ADD:     return a + b;
      SUB:     return a - b;
      MULT:    return a * b;
      DIV:     return (b == 0) ? 0 : a / b;
      MOD:     return (b == 0) ? 0 : a % b;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_div_zero(input instruction_t ins);
    return (ins.opc == DIV || ins.opc == MOD) && ins.op_b == 0;
  endfunction

  function automatic instruction_t make_instr(input logic [3:0] opc, input int a, input int b);
    instruction_t r;
    r.opc  = opcode_t'(opc);
    r.op_a = operand_t'(a);
    r.op_b = operand_t'(b);
    return r;
  endfunction

  function automatic instruction_t rand_instr();
    instruction_t r;
    r.opc  = opcode_t'(4'($urandom_range(0, 15)));
    r.op_a = ($urandom_range(0, 7) == 0) ? operand_t'(0) : operand_t'($urandom);
    r.op_b = ($urandom_range(0, 3) == 0) ? operand_t'(0) : operand_t'($urandom);
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 32; i++) mem[i] = rand_instr();
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"},     64'(state_dbg),            64'(IDLE));
    check_eq({tag, "_rp"},        64'(bus_if.read_pointer),  64'(0));
    check_eq({tag, "_valid"},     64'(bus_if.res_valid),     64'(0));
    check_eq({tag, "_data"},      64'(bus_if.res_data),      64'(0));
    check_eq({tag, "_opcode"},    64'(bus_if.res_opcode),    64'(ZERO));
    check_eq({tag, "_addr"},      64'(bus_if.res_addr),      64'(0));
    check_eq({tag, "_busy"},      64'(busy),                 64'(0));
    check_eq({tag, "_done"},      64'(done),                 64'(0));
    check_eq({tag, "_dz"},        64'(div_zero_err),         64'(0));
`ifdef SEQ_STALL_CNT_EN
    check_eq({tag, "_stall"},     64'(stall_cnt),            64'(0));
`endif
  endtask

  // One full sweep: start pulse, consume results with the chosen ready
  // policy, compare against the queued model values, check done timing.
  task automatic run_sweep(input logic [4:0] sa, input logic [5:0] cnt, input int stall_pct,
                           input int hold_first, input bit poke);
    logic [63:0] exp_q[$];
    logic [4:0]  exp_addr_q[$];
    logic [3:0]  exp_opc_q[$];
    logic [4:0]  a;
    logic [63:0] hold_data;
    logic [4:0]  hold_rp;
    bit          exp_dz;
    bit          seen_done;
    bit          holding;
    bit          first_valid;
    int          stall_exp;
    int          cyc;
    int          last_hs;
    int          held;

    exp_dz = 0;
    for (int i = 0; i < int'(cnt); i++) begin
      a = 5'((int'(sa) + i) % 32);
      exp_addr_q.push_back(a);
      exp_opc_q.push_back(mem[a].opc);
      exp_q.push_back(model_res(mem[a]));
      if (is_div_zero(mem[a])) exp_dz = 1;
    end

    @(negedge clk);
    start      = 1'b1;
    start_addr = sa;
    count      = cnt;
    seen_done  = 0;
    holding    = 0;
    first_valid = 0;
    stall_exp  = 0;
    cyc        = 0;
    last_hs    = -10;
    held       = 0;

    while (!seen_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = (poke && cyc == 2);
      if (start) begin
        start_addr = 5'($urandom_range(0, 31));
        count      = 6'($urandom_range(1, 32));
      end
      if (cyc == 1) begin
        check_eq("busy_after_start", 64'(busy), 64'(cnt != 0));
        check_eq("dz_cleared_by_start", 64'(div_zero_err), 64'(0));
      end
      if (holding) begin
        check_eq("hold_valid", 64'(bus_if.res_valid), 64'(1));
        check_eq("hold_data", bus_if.res_data, hold_data);
        check_eq("hold_rp", 64'(bus_if.read_pointer), 64'(hold_rp));
        holding = 0;
      end
      if (bus_if.res_valid && !first_valid) begin
        first_valid = 1;
        check_eq("first_latency", 64'(cyc), 64'(3));
      end
      if (done) begin
        seen_done = 1;
        check_eq("done_timing", 64'(cyc), (cnt == 0) ? 64'(1) : 64'(last_hs + 1));
        check_eq("dz_at_done", 64'(div_zero_err), 64'(exp_dz));
        check_eq("results_left", 64'(exp_q.size()), 64'(0));
        check_eq("busy_at_done", 64'(busy), 64'(0));
        check_eq("valid_at_done", 64'(bus_if.res_valid), 64'(0));
`ifdef SEQ_STALL_CNT_EN
        check_eq("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
`endif
      end
      if (bus_if.res_valid && held < hold_first) begin
        res_ready = 1'b0;
        held++;
      end else begin
        res_ready = ($urandom_range(0, 99) >= stall_pct);
      end
      if (bus_if.res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_result", 64'(1), 64'(0));
        end else begin
          check_eq("res_data", bus_if.res_data, exp_q.pop_front());
          check_eq("res_addr", 64'(bus_if.res_addr), 64'(exp_addr_q.pop_front()));
          check_eq("res_opcode", 64'(bus_if.res_opcode), 64'(exp_opc_q.pop_front()));
        end
        last_hs = cyc;
      end else if (bus_if.res_valid) begin
        holding   = 1;
        hold_data = bus_if.res_data;
        hold_rp   = bus_if.read_pointer;
        stall_exp++;
      end
    end
    start = 1'b0;
    if (!seen_done) check_eq("done_timeout", 64'(0), 64'(1));

    repeat (3) begin
      @(negedge clk);
      check_eq("quiet_done", 64'(done), 64'(0));
      check_eq("quiet_valid", 64'(bus_if.res_valid), 64'(0));
    end
    check_eq("dz_after_sweep", 64'(div_zero_err), 64'(exp_dz));
  endtask

  // Start a sweep, pull reset while the first entry is in EXEC.
  task automatic reset_mid_sweep();
    @(negedge clk);
    start      = 1'b1;
    start_addr = 5'd10;
    count      = 6'd4;
    res_ready  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("mid_state_exec", 64'(state_dbg), 64'(EXEC));
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_no_done", 64'(done), 64'(0));
      check_eq("rst_no_valid", 64'(bus_if.res_valid), 64'(0));
    end
    reset_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n    = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    res_ready  = 1'b0;
    fill_random();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Basic ordering with known arithmetic.
    mem[0] = make_instr(4'(ADD), 5, 3);
    mem[1] = make_instr(4'(SUB), 2, 7);
    mem[2] = make_instr(4'(MULT), -4, 6);
    mem[3] = make_instr(4'(PASSB), 0, 9);
    check_eq("basic_model_0", 64'(model_res(mem[0])), 64'(8));
    check_eq("basic_model_2", 64'(model_res(mem[2])), 64'(-24));
    run_sweep(5'd0, 6'd4, 0, 0, 1'b0);

    // Wrap across the top of the register, then an empty sweep.
    fill_random();
    run_sweep(5'd30, 6'd4, 0, 0, 1'b0);
    run_sweep(5'd7, 6'd0, 0, 0, 1'b0);

    // Backpressure: first result held for 5 cycles.
    run_sweep(5'd0, 6'd3, 0, 5, 1'b0);

    // Divide by zero followed by a valid modulo; next start clears the flag.
    mem[5] = make_instr(4'(DIV), 10, 0);
    mem[6] = make_instr(4'(MOD), 7, 3);
    mem[7] = make_instr(4'(ADD), 1, 1);
    run_sweep(5'd5, 6'd2, 0, 0, 1'b0);
    run_sweep(5'd7, 6'd1, 0, 0, 1'b0);

    // Start pulse while busy must be ignored.
    run_sweep(5'($urandom_range(0, 31)), 6'd5, 20, 0, 1'b1);

    // Reset in EXEC, then a normal sweep.
    reset_mid_sweep();
    run_sweep(5'd2, 6'd3, 0, 0, 1'b0);

    // Full-depth sweep and random sweeps.
    fill_random();
    run_sweep(5'($urandom_range(0, 31)), 6'd32, 30, 0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      fill_random();
      run_sweep(5'($urandom_range(0, 31)), 6'($urandom_range(0, 32)),
                $urandom_range(0, 60), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

  // Global time bound in case a handshake never completes.
  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
